// File: rtl/nn_pkg.sv
// Shared fixed-point constants for the neuron datapath, weight memory and later layers.
package nn_pkg;
  localparam int NN_DATA_W    = 16;
  localparam int NN_FRAC_BITS = 8;

  // Guard bits absorb the growth from summing many full-scale products.
  function automatic int acc_width(input int dw);
    return 2*dw + 10;
  endfunction

  localparam int NN_ACC_W = acc_width(NN_DATA_W);
  localparam logic [NN_DATA_W-1:0] NN_OUT_MAX = {1'b0, {(NN_DATA_W-1){1'b1}}};
  localparam logic [NN_DATA_W-1:0] NN_OUT_MIN = '0;
endpackage

// File: rtl/relu_act.sv
// ReLU on the full-width pre-activation. With MAC_SAT_EN, positive overflow clamps to
// the max output word; otherwise the low dataWidth bits pass through and may wrap.
module relu_act import nn_pkg::*; #(
  parameter int dataWidth = NN_DATA_W,
  parameter int accWidth  = NN_ACC_W
) (
  input  logic signed [accWidth-1:0]  r,
  output logic        [dataWidth-1:0] y
);
  localparam logic signed [accWidth-1:0] ZERO = '0;
`ifdef MAC_SAT_EN
  localparam logic signed [accWidth-1:0] MAX_R = (accWidth'(1) <<< (dataWidth-1)) - accWidth'(1);
`endif

  always_comb begin
    y = '0;
    if (r < ZERO)
      y = '0;
    else begin
`ifdef MAC_SAT_EN
      if (r > MAX_R) y = MAX_R[dataWidth-1:0];
      else           y = r[dataWidth-1:0];
`else
      y = r[dataWidth-1:0];
`endif
    end
  end
endmodule

// File: rtl/neuron_mac.sv
// Per-neuron MAC: one weight read per input, 4-stage multiply/accumulate/bias/ReLU pipe.
// Build option MAC_SAT_EN selects clamping (vs wrapping) of positive output overflow.
module neuron_mac import nn_pkg::*; #(
  parameter int numWeight    = 3,
  parameter int addressWidth = 10,
  parameter int dataWidth    = NN_DATA_W,
  parameter int fracBits     = NN_FRAC_BITS,
  parameter int accWidth     = acc_width(dataWidth)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [dataWidth-1:0]    in_data,
  input  logic                    in_valid,
  output logic                    w_ren,
  output logic [addressWidth-1:0] w_radd,
  input  logic [dataWidth-1:0]    w_data,
  input  logic [dataWidth-1:0]    bias,
  output logic [dataWidth-1:0]    out,
  output logic                    out_valid
);
  localparam logic [addressWidth-1:0] LAST_ADDR = addressWidth'(numWeight-1);

  logic [addressWidth-1:0]      cnt;
  logic                         last;
  logic [3:1]                   vld_pipe;  // [3] is the pass-done flag
  logic [2:1]                   lst_pipe;
  logic signed [dataWidth-1:0]  in_d;
  logic signed [2*dataWidth-1:0] prod;
  logic signed [accWidth-1:0]   acc, sum_r, r_w;
  logic [dataWidth-1:0]         act_y;

  assign w_ren  = in_valid;
  assign w_radd = cnt;
  assign last   = in_valid && (cnt == LAST_ADDR);
  assign r_w    = (sum_r >>> fracBits) + accWidth'($signed(bias));

  relu_act #(.dataWidth(dataWidth), .accWidth(accWidth)) u_act (.r(r_w), .y(act_y));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      vld_pipe  <= '0;
      lst_pipe  <= '0;
      in_d      <= '0;
      prod      <= '0;
      acc       <= '0;
      sum_r     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_valid) cnt <= last ? '0 : cnt + 1'b1;

      in_d        <= $signed(in_data);
      vld_pipe[1] <= in_valid;
      lst_pipe[1] <= last;

      prod        <= in_d * $signed(w_data);
      vld_pipe[2] <= vld_pipe[1];
      lst_pipe[2] <= lst_pipe[1];

      // Clearing acc on the last product lets a back-to-back pass start from 0.
      if (vld_pipe[2]) begin
        if (lst_pipe[2]) begin
          sum_r <= acc + accWidth'(prod);
          acc   <= '0;
        end else begin
          acc   <= acc + accWidth'(prod);
        end
      end
      vld_pipe[3] <= vld_pipe[2] && lst_pipe[2];

      out_valid <= vld_pipe[3];
      if (vld_pipe[3]) out <= act_y;
    end
  end
endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: directed passes push expected words, a monitor pops them.
module tb_neuron_mac;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        w_ren;
  logic [9:0]  w_radd;
  logic [15:0] w_data;
  logic [15:0] bias;
  logic [15:0] out;
  logic        out_valid;

  typedef struct { logic [15:0] val; int cyc; } exp_t;
  exp_t        sb[$];
  logic [15:0] mem [3];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          exp_addr = 0;

  neuron_mac dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .w_ren(w_ren), .w_radd(w_radd), .w_data(w_data), .bias(bias),
    .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Weight memory model: one-cycle read latency.
  always @(posedge clk) if (w_ren) w_data <= mem[w_radd[1:0]];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every out_valid must match the oldest expectation, value and cycle.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_out: got 0x%0h expected no out_valid", out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_value", 32'(out), 32'(e.val));
        check("out_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic send(input logic [15:0] d, input bit is_last, input logic [15:0] exp_out);
    if (is_last) sb.push_back('{val: exp_out, cyc: cyc + 4});
    in_data = d; in_valid = 1'b1;
    #1;
    check("w_ren", 32'(w_ren), 32'd1);
    check("w_radd", 32'(w_radd), 32'(exp_addr));
    exp_addr = (exp_addr == 2) ? 0 : exp_addr + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pass3(input logic [15:0] a, b, c, input logic [15:0] exp_out);
    send(a, 0, 16'h0); send(b, 0, 16'h0); send(c, 1, exp_out);
  endtask

  initial begin
    logic [15:0] sat_exp;
`ifdef MAC_SAT_EN
    sat_exp = 16'h7FFF;
`else
    sat_exp = 16'h0300;
`endif
    rst = 1'b1; in_data = '0; in_valid = 1'b0; bias = '0; w_data = '0;
    mem[0] = 16'h0100; mem[1] = 16'h0200; mem[2] = 16'h0080;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'(out), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_w_radd", 32'(w_radd), 32'h0);
    check("rst_w_ren", 32'(w_ren), 32'h0);
    rst = 1'b0;
    idle(1);

    // Basic: 1*1 + 1*2 + 2*0.5 = 4.0
    pass3(16'h0100, 16'h0100, 16'h0200, 16'h0400);
    #1 check("w_radd_wrap", 32'(w_radd), 32'h0);
    idle(6);

    // Bias: 3.0 + 0.5
    mem[0] = 16'h0100; mem[1] = 16'h0100; mem[2] = 16'h0100; bias = 16'h0080;
    pass3(16'h0100, 16'h0100, 16'h0100, 16'h0380);
    idle(6);
    // Negative sum -> ReLU 0
    mem[0] = 16'hFF00; mem[1] = 16'hFF00; mem[2] = 16'hFF00;
    pass3(16'h0100, 16'h0100, 16'h0100, 16'h0000);
    idle(6);

    // Overflow: 3 * 127*127 = 48387.0, low 16 bits 0x0300
    bias = 16'h0000;
    mem[0] = 16'h7F00; mem[1] = 16'h7F00; mem[2] = 16'h7F00;
    pass3(16'h7F00, 16'h7F00, 16'h7F00, sat_exp);
    idle(6);

    // Truncation: 3 * 0.5 LSB = 1.5 LSB -> 1
    mem[0] = 16'h0080; mem[1] = 16'h0080; mem[2] = 16'h0080;
    pass3(16'h0001, 16'h0001, 16'h0001, 16'h0001);
    idle(6);

    // Gaps then back-to-back: 6.5 then 0.5+2-0.5 = 2.0
    mem[0] = 16'h0100; mem[1] = 16'h0200; mem[2] = 16'h0080;
    send(16'h0100, 0, 16'h0); idle(2);
    send(16'h0200, 0, 16'h0); send(16'h0300, 1, 16'h0680);
    send(16'h0080, 0, 16'h0); send(16'h0100, 0, 16'h0); send(16'hFF00, 1, 16'h0200);
    idle(8);

    // Reset mid-pass discards partial sum and restarts at address 0
    send(16'h0100, 0, 16'h0); send(16'h0100, 0, 16'h0);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_w_radd", 32'(w_radd), 32'h0);
    #1 rst = 1'b0;
    exp_addr = 0;
    idle(6);
    pass3(16'h0100, 16'h0100, 16'h0200, 16'h0400);

    for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
    idle(2);
    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
